// File: rtl/rgb_bram_rd_sched.sv
// rgb_bram_rd_sched: read-port scheduler for the shared R/G/B input BRAMs.
// SA is the primary requester; DBG is served when SA is idle or once SA has
// taken STARVE_LIMIT consecutive grants while DBG waited. ps_busy blocks all
// grants. Each grant returns one packed word RD_LATENCY+2 cycles later.
// Optional: define RGB_SCHED_PERF_EN for saturating grant/stall counters.
module rgb_bram_rd_sched #(
  parameter int ADDR_WIDTH   = 13,
  parameter int PIX_WIDTH    = 16,
  parameter int MAX_ADDR     = 7056,
  parameter int RD_LATENCY   = 2,
  parameter int STARVE_LIMIT = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ps_busy,
  input  logic                  sa_req,
  input  logic [ADDR_WIDTH-1:0] sa_addr,
  output logic                  sa_gnt,
  input  logic                  dbg_req,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  output logic                  dbg_gnt,
  output logic                  bram_en,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  input  logic [PIX_WIDTH-1:0]  bram_dout_r,
  input  logic [PIX_WIDTH-1:0]  bram_dout_g,
  input  logic [PIX_WIDTH-1:0]  bram_dout_b,
  output logic [63:0]           rdata,
  output logic                  rdata_valid,
  output logic                  rdata_owner,
  output logic [1:0]            sched_state,
  output logic [31:0]           perf_sa,
  output logic [31:0]           perf_dbg,
  output logic [31:0]           perf_stall
);
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SA = 2'd1, ST_DBG = 2'd2, ST_STALL = 2'd3} state_t;

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0]         STARVE_MAX = CW'(STARVE_LIMIT);
  localparam logic [ADDR_WIDTH:0]   MAX_A      = (ADDR_WIDTH + 1)'(MAX_ADDR);

  state_t                  state_q, state_d;
  logic [CW-1:0]           starve_q, starve_d;
  logic                    bram_en_q, bram_en_d;
  logic [ADDR_WIDTH-1:0]   bram_addr_q, bram_addr_d;
  logic [RD_LATENCY:0]     vld_pipe_q, vld_pipe_d;
  logic [RD_LATENCY:0]     own_pipe_q, own_pipe_d;
  logic [RD_LATENCY:0]     pad_pipe_q, pad_pipe_d;
  logic [63:0]             rdata_q, rdata_d;
  logic                    rdata_valid_q, rdata_valid_d;
  logic                    rdata_owner_q, rdata_owner_d;
  logic                    gnt_any, gnt_pad;
  logic [ADDR_WIDTH-1:0]   gnt_addr;

  // Grant arbitration: busy blocks everything, DBG wins when SA idle or starved.
  always_comb begin
    sa_gnt  = 1'b0;
    dbg_gnt = 1'b0;
    if (rst_n && !ps_busy) begin
      if (dbg_req && (!sa_req || starve_q == STARVE_MAX)) dbg_gnt = 1'b1;
      else if (sa_req)                                   sa_gnt  = 1'b1;
    end
    gnt_any  = sa_gnt | dbg_gnt;
    gnt_addr = dbg_gnt ? dbg_addr : sa_addr;
    gnt_pad  = ({1'b0, gnt_addr} >= MAX_A);
  end

  // Next-state for FSM, starvation counter, issue stage and return pipeline.
  always_comb begin
    if (ps_busy)      state_d = ST_STALL;
    else if (sa_gnt)  state_d = ST_SA;
    else if (dbg_gnt) state_d = ST_DBG;
    else              state_d = ST_IDLE;

    starve_d = starve_q;
    if (!ps_busy) begin
      if (dbg_gnt || !dbg_req)                   starve_d = '0;
      else if (sa_gnt && starve_q != STARVE_MAX) starve_d = starve_q + 1'b1;
    end

    bram_en_d   = gnt_any && !gnt_pad;
    bram_addr_d = gnt_any ? gnt_addr : bram_addr_q;

    vld_pipe_d = {vld_pipe_q[RD_LATENCY-1:0], gnt_any};
    own_pipe_d = {own_pipe_q[RD_LATENCY-1:0], dbg_gnt};
    pad_pipe_d = {pad_pipe_q[RD_LATENCY-1:0], gnt_pad};

    rdata_valid_d = vld_pipe_q[RD_LATENCY];
    rdata_d       = rdata_q;
    rdata_owner_d = rdata_owner_q;
    if (vld_pipe_q[RD_LATENCY]) begin
      rdata_owner_d = own_pipe_q[RD_LATENCY];
      rdata_d       = pad_pipe_q[RD_LATENCY] ? 64'd0 :
                      {{(64 - 3 * PIX_WIDTH){1'b0}}, bram_dout_r, bram_dout_g, bram_dout_b};
    end
  end

  // State registers; reset drops any reads still in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      starve_q      <= '0;
      bram_en_q     <= 1'b0;
      bram_addr_q   <= '0;
      vld_pipe_q    <= '0;
      own_pipe_q    <= '0;
      pad_pipe_q    <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      rdata_owner_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      starve_q      <= starve_d;
      bram_en_q     <= bram_en_d;
      bram_addr_q   <= bram_addr_d;
      vld_pipe_q    <= vld_pipe_d;
      own_pipe_q    <= own_pipe_d;
      pad_pipe_q    <= pad_pipe_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      rdata_owner_q <= rdata_owner_d;
    end
  end

  assign sched_state = state_q;
  assign bram_en     = bram_en_q;
  assign bram_addr   = bram_addr_q;
  assign rdata       = rdata_q;
  assign rdata_valid = rdata_valid_q;
  assign rdata_owner = rdata_owner_q;

`ifdef RGB_SCHED_PERF_EN
  logic [31:0] perf_sa_q, perf_sa_d, perf_dbg_q, perf_dbg_d, perf_stall_q, perf_stall_d;

  // Saturating event counters.
  always_comb begin
    perf_sa_d    = perf_sa_q;
    perf_dbg_d   = perf_dbg_q;
    perf_stall_d = perf_stall_q;
    if (sa_gnt && perf_sa_q != 32'hFFFF_FFFF)   perf_sa_d  = perf_sa_q + 32'd1;
    if (dbg_gnt && perf_dbg_q != 32'hFFFF_FFFF) perf_dbg_d = perf_dbg_q + 32'd1;
    if (ps_busy && (sa_req | dbg_req) && perf_stall_q != 32'hFFFF_FFFF)
      perf_stall_d = perf_stall_q + 32'd1;
  end

  // Counter registers, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_sa_q    <= '0;
      perf_dbg_q   <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_sa_q    <= perf_sa_d;
      perf_dbg_q   <= perf_dbg_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_sa    = perf_sa_q;
  assign perf_dbg   = perf_dbg_q;
  assign perf_stall = perf_stall_q;
`else
  assign perf_sa    = 32'd0;
  assign perf_dbg   = 32'd0;
  assign perf_stall = 32'd0;
`endif
endmodule

// File: tb/tb_rgb_bram_rd_sched.sv
// Directed bench for rgb_bram_rd_sched with a 2-cycle BRAM model and an
// in-order scoreboard checking data, owner and grant-to-return latency.
module tb_rgb_bram_rd_sched;
  localparam int AW = 13;
  localparam int MAXA = 7056;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ps_busy = 1'b0, sa_req = 1'b0, dbg_req = 1'b0;
  logic [AW-1:0] sa_addr = '0, dbg_addr = '0;
  logic          sa_gnt, dbg_gnt, bram_en, rdata_valid, rdata_owner;
  logic [AW-1:0] bram_addr;
  logic [15:0]   bram_dout_r, bram_dout_g, bram_dout_b;
  logic [63:0]   rdata;
  logic [1:0]    sched_state;
  logic [31:0]   perf_sa, perf_dbg, perf_stall;

  int checks = 0, errors = 0, cyc = 0, ret_cnt = 0;
  logic [63:0] exp_q[$];
  logic        own_q[$];
  int          cyc_q[$];

  rgb_bram_rd_sched dut (
    .clk(clk), .rst_n(rst_n), .ps_busy(ps_busy),
    .sa_req(sa_req), .sa_addr(sa_addr), .sa_gnt(sa_gnt),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_gnt(dbg_gnt),
    .bram_en(bram_en), .bram_addr(bram_addr),
    .bram_dout_r(bram_dout_r), .bram_dout_g(bram_dout_g), .bram_dout_b(bram_dout_b),
    .rdata(rdata), .rdata_valid(rdata_valid), .rdata_owner(rdata_owner),
    .sched_state(sched_state),
    .perf_sa(perf_sa), .perf_dbg(perf_dbg), .perf_stall(perf_stall)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [47:0] pix(input int a);
    logic [15:0] v;
    v = 16'(a);
    return {v, v ^ 16'h5A5A, 16'(a * 3 + 7)};
  endfunction

  // BRAM model: address sampled one edge after bram_addr appears, data one edge later.
  logic [AW-1:0] m_a1 = '0;
  logic          m_en1 = 1'b0;
  always @(posedge clk) begin
    m_en1 <= bram_en;
    if (bram_en) m_a1 <= bram_addr;
    if (m_en1) {bram_dout_r, bram_dout_g, bram_dout_b} <= pix(int'(m_a1));
  end
  initial {bram_dout_r, bram_dout_g, bram_dout_b} = 48'hDEAD_BEEF_0BAD;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at cyc %0d", tag, got, exp, cyc);
    end
  endtask

  // Scoreboard: record every grant, match every return in order.
  always @(negedge clk) if (rst_n) begin
    if (rdata_valid) begin
      if (exp_q.size() == 0) chk("unexp_ret", 1, 0);
      else begin
        chk("rdata", rdata, exp_q.pop_front());
        chk("owner", rdata_owner, own_q.pop_front());
        chk("latency", cyc - cyc_q.pop_front(), 4);
        ret_cnt++;
      end
    end
    if (sa_gnt | dbg_gnt) begin
      int a;
      a = dbg_gnt ? int'(dbg_addr) : int'(sa_addr);
      exp_q.push_back(a >= MAXA ? 64'd0 : {16'd0, pix(a)});
      own_q.push_back(dbg_gnt);
      cyc_q.push_back(cyc);
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      sa_req = 0; dbg_req = 0; ps_busy = 0;
    end
    @(negedge clk); #2;
    chk("drain", exp_q.size(), 0);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_gnt"}, {sa_gnt, dbg_gnt}, 0);
    chk({tag, "_en"}, bram_en, 0);
    chk({tag, "_addr"}, bram_addr, 0);
    chk({tag, "_rdata"}, rdata, 0);
    chk({tag, "_vld"}, {rdata_valid, rdata_owner}, 0);
    chk({tag, "_state"}, sched_state, 0);
  endtask

  // SA streams n addresses from start; ps_busy is high for busy_len cycles at busy_at.
  task automatic sa_stream(input int start, input int n, input int busy_at, input int busy_len);
    int a, c, prev_a;
    logic busy, prev_g, prev_busy;
    a = start; c = 0; prev_a = 0; prev_g = 0; prev_busy = 0;
    while (a < start + n) begin
      @(posedge clk); #1;
      busy = (c >= busy_at) && (c < busy_at + busy_len);
      ps_busy = busy; sa_req = 1; sa_addr = AW'(a);
      @(negedge clk); #2;
      chk("sa_gnt", sa_gnt, !busy);
      if (c > 0) begin
        chk("state", sched_state, prev_busy ? 3 : (prev_g ? 1 : 0));
        chk("bram_en", bram_en, prev_g && prev_a < MAXA);
        if (prev_g) chk("bram_addr", bram_addr, prev_a);
      end
      prev_g = !busy; prev_a = a; prev_busy = busy;
      if (!busy) a++;
      c++;
    end
    @(posedge clk); #1;
    sa_req = 0; ps_busy = 0;
    @(negedge clk); #2;
    chk("bram_en_last", bram_en, prev_a < MAXA);
    chk("bram_addr_last", bram_addr, prev_a);
    idle(6);
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk); #2;
    check_zero_outputs("rst");
    chk("perf_rst", {perf_sa, perf_stall}, 0);
    @(posedge clk); #1 rst_n = 1;

    // 1: reset at the 5th return of a 0..9 stream
    begin
      int a;
      a = 0;
      for (int i = 0; i < 20 && ret_cnt < 5; i++) begin
        @(posedge clk); #1;
        sa_req = (a <= 9); sa_addr = AW'(a);
        @(negedge clk); #2;
        if (sa_gnt) a++;
      end
      chk("t1_ret5", ret_cnt, 5);
      rst_n = 0; sa_req = 0;
      exp_q.delete(); own_q.delete(); cyc_q.delete();
      @(negedge clk); #2;
      check_zero_outputs("t1");
      @(posedge clk); #1 rst_n = 1;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk); #2;
        chk("t1_stale", rdata_valid, 0);
      end
    end

    // 2: full image stream
    sa_stream(0, MAXA, 1 << 30, 0);
    // 3: image edge and padding
    sa_stream(MAXA - 2, 5, 1 << 30, 0);
    sa_stream((1 << AW) - 1, 1, 1 << 30, 0);
    // 5: busy pulse mid-stream with reads in flight
    sa_stream(500, 20, 4, 5);
`ifdef RGB_SCHED_PERF_EN
    chk("perf_stall", perf_stall, 5);
`else
    chk("perf_tied", {perf_sa, perf_dbg, perf_stall}, 0);
`endif

    // 6: lone DBG request
    @(posedge clk); #1 dbg_req = 1; dbg_addr = 100;
    @(negedge clk); #2;
    chk("t6_dbg_gnt", {sa_gnt, dbg_gnt}, 2'b01);
    @(posedge clk); #1 dbg_req = 0;
    @(negedge clk); #2;
    chk("t6_state", sched_state, 2);
    chk("t6_issue", {bram_en, bram_addr}, {1'b1, 13'd100});
    idle(6);

    // 4: SA and DBG contending: 16 SA then 1 DBG, repeating
    begin
      int sa_a, dbg_a;
      logic exp_dbg, prev_dbg;
      sa_a = 200; dbg_a = 300; prev_dbg = 0;
      for (int i = 0; i < 40; i++) begin
        @(posedge clk); #1;
        sa_req = 1; dbg_req = 1; sa_addr = AW'(sa_a); dbg_addr = AW'(dbg_a);
        @(negedge clk); #2;
        exp_dbg = (i % 17) == 16;
        chk("t4_gnt", {sa_gnt, dbg_gnt}, exp_dbg ? 2'b01 : 2'b10);
        if (i > 0) chk("t4_state", sched_state, prev_dbg ? 2 : 1);
        if (dbg_gnt) dbg_a++;
        if (sa_gnt) sa_a++;
        prev_dbg = exp_dbg;
      end
      idle(6);
    end

    // Boundary: padding requested by DBG too
    @(posedge clk); #1 dbg_req = 1; dbg_addr = AW'(MAXA);
    @(negedge clk); #2;
    chk("pad_dbg_gnt", dbg_gnt, 1);
    @(posedge clk); #1 dbg_req = 0;
    @(negedge clk); #2;
    chk("pad_dbg_en", bram_en, 0);
    idle(6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
